// File: rtl/uart_tx_arbiter.sv
// Two-channel UART transmitter: round-robin arbitration between two byte requesters,
// 12-bit frame build (start, 8 data LSB first, parity, 2 stop) and serialization on tx.
module uart_tx_arbiter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [7:0]  data0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic        tx,
    output logic        busy,
    output logic        ch,
    output logic [11:0] frame
);

    localparam int unsigned   CntW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic              pri_q, pri_d;
    logic              ch_q, ch_d;
    logic [11:0]       frame_q, frame_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    logic              grant1;
    logic [7:0]        sel_data;
    logic [7:0]        line_data;
    logic [2:0]        data_idx;
    logic              line_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            pri_q   <= 1'b0;
            ch_q    <= 1'b0;
            frame_q <= 12'h003;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            pri_q   <= pri_d;
            ch_q    <= ch_d;
            frame_q <= frame_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Channel 1 wins when it is the only requester or when it holds the priority pointer.
    assign grant1   = req1 & (~req0 | pri_q);
    assign sel_data = grant1 ? data1 : data0;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pri_d   = pri_q;
        ch_d    = ch_q;
        frame_d = frame_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StSend;
                    ch_d    = grant1;
                    pri_d   = ~grant1;
                    ack0_d  = ~grant1;
                    ack1_d  = grant1;
                    frame_d = {1'b0, sel_data, ^sel_data ^ PARITY_ODD, 2'b11};
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            StSend: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line order: start, data LSB first, parity, stop, stop.
    assign line_data = frame_q[10:3];
    assign data_idx  = 3'(bit_q - 4'd1);

    always_comb begin
        line_bit = 1'b1;
        case (bit_q)
            4'd0:    line_bit = frame_q[11];
            4'd9:    line_bit = frame_q[2];
            4'd10:   line_bit = frame_q[1];
            4'd11:   line_bit = frame_q[0];
            default: line_bit = line_data[data_idx];
        endcase
    end

    assign tx    = (state_q == StSend) ? line_bit : 1'b1;
    assign busy  = (state_q == StSend);
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign ch    = ch_q;
    assign frame = frame_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-channel UART transmit controller that shares one serial line between two byte requesters. It arbitrates requests round-robin and builds the 12-bit frame (start, 8 data, parity, 2 stop). It then serializes the frame on TX at a programmable baud rate. It sits between the byte producers and the pad, and owns all sequencing of the frame datapath.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2.
- PARITY_ODD, 0, 0 = even parity (^DATA), 1 = odd parity (~^DATA).

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- REQ0  input  1  channel 0 request; held until ACK0.
- DATA0  input  8  channel 0 byte; stable while REQ0 high.
- REQ1  input  1  channel 1 request; held until ACK1.
- DATA1  input  8  channel 1 byte; stable while REQ1 high.
- ACK0  output  1  one-cycle pulse: DATA0 captured.
- ACK1  output  1  one-cycle pulse: DATA1 captured.
- TX  output  1  serial line, idle high.
- BUSY  output  1  high while a frame is on the line.
- CH  output  1  channel owning the current/last frame.
- FRAME  output  12  latched frame with this layout:
  - [11] start = 0.
  - [10:3] data.
  - [2] parity.
  - [1:0] stop = 2'b11.

## Operation
- States: IDLE, SEND.
- IDLE: TX=1, BUSY=0.
  - If REQ0 or REQ1 is sampled high, the next edge performs all of the following:
    - Select the winner k.
    - Assert ACKk for exactly one cycle.
    - Load FRAME from DATAk.
    - Set CH=k, TX=0 (start bit), BUSY=1.
    - Clear the bit and baud counters.
    - Go to SEND.
- Arbitration: a priority pointer PRI starts at 0.
  - Single requester: it wins.
  - Both requesting: channel PRI wins.
  - After any grant to k, PRI becomes ~k, so alternation is strict under contention.
- Parity bit = ^DATAk ^ PARITY_ODD.
- Line bit order, 12 bits total:
  - FRAME[11] (start).
  - FRAME[3], FRAME[4], …, FRAME[10] (data, LSB first).
  - FRAME[2] (parity).
  - FRAME[1], FRAME[0] (stop).
- SEND counters:
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - At terminal count it wraps and the bit counter (0..11) advances; TX drives the next bit.
  - At terminal count of bit 11, the next edge goes to IDLE: TX=1, BUSY=0.
- Requests arriving during SEND are not sampled. They are arbitrated in the first IDLE cycle.
- A requester must drop REQ in the ACK cycle. REQ still high after ACK is treated as a new request at the next IDLE.
- FRAME and CH hold their values after the frame ends, until the next grant.

## Timing
- Reset values (asynchronous, immediate): TX=1, BUSY=0, ACK0=ACK1=0, CH=0, FRAME=12'h003, PRI=0, state=IDLE, counters=0.
- Grant latency: REQ sampled high in an IDLE cycle gives ACK, FRAME valid and TX start bit on the following edge.
- Each bit is exactly CLKS_PER_BIT cycles. BUSY is high for exactly 12·CLKS_PER_BIT cycles per frame.
- Back-to-back frames have exactly 1 IDLE cycle (TX=1) between stop bit 2 and the next start bit.
- Reset during SEND aborts the frame. TX returns high at once, the frame is not resumed, and no ACK is re-issued. The requester's byte is already consumed.
- Simultaneous REQ0/REQ1 in IDLE: only one ACK is issued. The loser's REQ stays pending.

## Test plan
- Reset: hold RST_N=0 with REQ0=REQ1=1 -> TX=1, BUSY=0, ACK0=ACK1=0, FRAME=12'h003; on release, ch0 is granted first.
- Single frame, CLKS_PER_BIT=4, PARITY_ODD=0, REQ0 with DATA0=8'hA5 -> expected response:
  - ACK0 one cycle after REQ0 is sampled.
  - FRAME=12'h52B, CH=0.
  - TX = 0,1,0,1,0,0,1,0,1,0,1,1, each bit 4 cycles.
  - BUSY high 48 cycles.
- Contention: REQ0 and REQ1 both held with new bytes after each ACK, for 3 frames -> grants go ch0, ch1, ch0 with 1 idle cycle between frames; CH and FRAME match each granted byte.
- Parity: DATA0=8'h01 -> FRAME[2]=1 with PARITY_ODD=0 and FRAME[2]=0 with PARITY_ODD=1; DATA0=8'h00 -> 0 and 1 respectively.
- Mid-frame request: REQ1 raised during bit 5 of a ch0 frame -> no ACK1 until the IDLE cycle after bit 11; ACK1 arrives exactly 1 cycle after BUSY falls.
- Reset mid-frame: assert RST_N=0 during bit 6 -> TX=1 and BUSY=0 the same instant; after release with REQ1 only, ch1 is granted and sends a complete, correct frame.
